apb_requester: RTL

APB_REQUESTER -- requirements
Module: apb_requester

---
 rtl/apb_requester.sv | 116 +++++++++++
 1 files changed

// File: rtl/apb_requester.sv
// APB requester: turns single commands into one APB transfer each and returns
// a response, with an ACCESS-phase timeout and a saturating error counter.
module apb_requester #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic       pclk,
   input  logic       prst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_write,
   input  logic [7:0] cmd_addr,
   input  logic [7:0] cmd_wdata,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_rdata,
   output logic       rsp_err,
   output logic       rsp_timeout,
   output logic       psel,
   output logic       penable,
   output logic       pwrite,
   output logic [7:0] paddr,
   output logic [7:0] pwdata,
   input  logic [7:0] prdata,
   input  logic       pready,
   input  logic       pslverr,
   output logic [7:0] err_cnt
);

   // Sparse encoding so that codes such as 3'b011 are illegal and recover to idle.
   typedef enum logic [2:0] {
      StIdle   = 3'b000,
      StSetup  = 3'b001,
      StAccess = 3'b010,
      StResp   = 3'b100
   } state_e;

   localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

   state_e     state_q;
   logic [7:0] acc_cnt_q;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hff) ? v : v + 8'd1;
   endfunction

   always_ff @(posedge pclk or negedge prst) begin
      if (!prst) begin
         state_q     <= StIdle;
         acc_cnt_q   <= 8'h00;
         pwrite      <= 1'b0;
         paddr       <= 8'h00;
         pwdata      <= 8'h00;
         rsp_rdata   <= 8'h00;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
         err_cnt     <= 8'h00;
      end else begin
         case (state_q)
            StIdle: begin
               if (cmd_valid) begin
                  pwrite  <= cmd_write;
                  paddr   <= cmd_addr;
                  pwdata  <= cmd_wdata;
                  state_q <= StSetup;
               end
            end
            StSetup: begin
               acc_cnt_q <= 8'h00;
               state_q   <= StAccess;
            end
            StAccess: begin
               // A completing slave takes priority over an expiring timeout.
               if (pready) begin
                  rsp_rdata   <= (!pwrite && !pslverr) ? prdata : 8'h00;
                  rsp_err     <= pslverr;
                  rsp_timeout <= 1'b0;
                  if (pslverr) begin
                     err_cnt <= sat_inc(err_cnt);
                  end
                  state_q <= StResp;
               end else if (acc_cnt_q == TimeoutLast) begin
                  rsp_rdata   <= 8'h00;
                  rsp_err     <= 1'b1;
                  rsp_timeout <= 1'b1;
                  err_cnt     <= sat_inc(err_cnt);
                  state_q     <= StResp;
               end else begin
                  acc_cnt_q <= acc_cnt_q + 8'd1;
               end
            end
            StResp: begin
               if (rsp_ready) begin
                  state_q <= StIdle;
               end
            end
            default: begin
               state_q     <= StIdle;
               acc_cnt_q   <= 8'h00;
               pwrite      <= 1'b0;
               paddr       <= 8'h00;
               pwdata      <= 8'h00;
               rsp_rdata   <= 8'h00;
               rsp_err     <= 1'b0;
               rsp_timeout <= 1'b0;
               err_cnt     <= 8'h00;
            end
         endcase
      end
   end

   assign cmd_ready = (state_q == StIdle);
   assign psel      = (state_q == StSetup) || (state_q == StAccess);
   assign penable   = (state_q == StAccess);
   assign rsp_valid = (state_q == StResp);

endmodule
